// File: rtl/seg_scan_ctrl.sv
// Scan scheduler for a 4-digit multiplexed seven-segment display.
// Per-digit dwell, optional blank gap, PWM duty and a frame-synchronous pattern buffer.
//
// state | meaning
// IDLE  | scan stopped, display dark
// ON    | digit idx selected, segments lit while cnt < duty
// BLANK | anti-ghosting gap, all selects off
module seg_scan_ctrl #(
    parameter int unsigned UUID = 0,
    parameter              NAME = ""
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] dig0,
    input  logic [7:0] dig1,
    input  logic [7:0] dig2,
    input  logic [7:0] dig3,
    input  logic       upd,
    input  logic [7:0] dwell,
    input  logic [7:0] blank,
    input  logic [7:0] duty,
    output logic       sel1,
    output logic       sel2,
    output logic       sel3,
    output logic       sel4,
    output logic [7:0] seg,
    output logic       frame,
    output logic       pending
);

    typedef enum logic [1:0] {IDLE, ON, BLANK} state_t;

    state_t          st, st_nxt;
    logic [1:0]      idx, idx_nxt;
    logic [7:0]      cnt, cnt_nxt;
    logic            frame_nxt;
    logic            apply;
    logic            adv;
    logic [3:0][7:0] active, shadow;
    logic [7:0]      dwell_last;
    logic            blank_done;
    logic [3:0]      sel_vec;

    assign dwell_last = (dwell == 8'd0) ? 8'd0 : dwell - 8'd1;
    // blank may be dropped to 0 while already in BLANK; end the gap immediately then
    assign blank_done = (blank == 8'd0) || (cnt >= blank - 8'd1);

    always_comb begin
        st_nxt    = st;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        frame_nxt = 1'b0;
        apply     = 1'b0;
        adv       = 1'b0;
        case (st)
            IDLE: begin
                if (enable) begin
                    st_nxt  = ON;
                    idx_nxt = 2'd0;
                    cnt_nxt = 8'd0;
                    apply   = 1'b1;
                end
            end
            ON: begin
                if (!enable) begin
                    st_nxt  = IDLE;
                    idx_nxt = 2'd0;
                    cnt_nxt = 8'd0;
                end else if (cnt >= dwell_last) begin
                    if (blank != 8'd0) begin
                        st_nxt  = BLANK;
                        cnt_nxt = 8'd0;
                    end else begin
                        adv = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            BLANK: begin
                if (!enable) begin
                    st_nxt  = IDLE;
                    idx_nxt = 2'd0;
                    cnt_nxt = 8'd0;
                end else if (blank_done) begin
                    adv = 1'b1;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: begin
                st_nxt  = IDLE;
                idx_nxt = 2'd0;
                cnt_nxt = 8'd0;
            end
        endcase
        if (adv) begin
            st_nxt  = ON;
            cnt_nxt = 8'd0;
            if (idx == 2'd3) begin
                idx_nxt   = 2'd0;
                frame_nxt = 1'b1;
                apply     = 1'b1;
            end else begin
                idx_nxt = idx + 2'd1;
            end
        end
    end

    always_comb begin
        sel_vec = 4'b0000;
        seg     = 8'h00;
        if (st == ON) begin
            sel_vec[idx] = 1'b1;
            if (cnt < duty)
                seg = active[idx];
        end
    end

    assign sel1 = sel_vec[0];
    assign sel2 = sel_vec[1];
    assign sel3 = sel_vec[2];
    assign sel4 = sel_vec[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= IDLE;
            idx     <= 2'd0;
            cnt     <= 8'd0;
            frame   <= 1'b0;
            pending <= 1'b0;
            active  <= '0;
            shadow  <= '0;
        end else begin
            st    <= st_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
            frame <= frame_nxt;
            // an upd landing on the boundary bypasses the shadow entirely
            if (apply && upd) begin
                active  <= {dig3, dig2, dig1, dig0};
                pending <= 1'b0;
            end else if (apply && pending) begin
                active  <= shadow;
                pending <= 1'b0;
            end else if (upd) begin
                shadow  <= {dig3, dig2, dig1, dig0};
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst, enable, upd;
    logic [7:0] dig0, dig1, dig2, dig3, dwell, blank, duty;
    logic       sel1, sel2, sel3, sel4, frame, pending;
    logic [7:0] seg;
    logic [3:0] sel_v;
    logic [7:0] pat [4];

    int vecs = 0;
    int errs = 0;

    assign sel_v = {sel4, sel3, sel2, sel1};

    always #5 clk = ~clk;

    seg_scan_ctrl #(.UUID(0), .NAME("tb")) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
        .upd(upd), .dwell(dwell), .blank(blank), .duty(duty),
        .sel1(sel1), .sel2(sel2), .sel3(sel3), .sel4(sel4),
        .seg(seg), .frame(frame), .pending(pending)
    );

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; upd = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // loads the standard patterns via the shadow, then enables; returns at first lit cycle
    task automatic start_scan(input logic [7:0] dw, input logic [7:0] bl, input logic [7:0] du);
        dig0 = pat[0]; dig1 = pat[1]; dig2 = pat[2]; dig3 = pat[3];
        dwell = dw; blank = bl; duty = du;
        upd = 1'b1;
        @(negedge clk);
        upd = 1'b0; enable = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; upd = 1'b1;
        dig0 = 8'hAA; dig1 = 8'hAA; dig2 = 8'hAA; dig3 = 8'hAA;
        dwell = 8'd3; blank = 8'd0; duty = 8'd255;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if ({sel_v, seg, frame, pending} !== 14'h0) begin
                errs++;
                $display("FAIL reset[%0d]: sel=%b seg=%h frame=%b pending=%b, want all 0", i, sel_v, seg, frame, pending);
            end
            vecs++;
            if (i == 1) begin
                rst = 1'b0; enable = 1'b0; upd = 1'b0;
            end
        end
    endtask

    task automatic test_basic();
        logic [3:0] es; logic [7:0] eg; logic ef; int d;
        do_reset();
        dig0 = pat[0]; dig1 = pat[1]; dig2 = pat[2]; dig3 = pat[3];
        dwell = 8'd3; blank = 8'd0; duty = 8'd255;
        upd = 1'b1;
        @(negedge clk);
        upd = 1'b0; enable = 1'b1;
        if (pending !== 1'b1 || sel_v !== 4'b0) begin
            errs++;
            $display("FAIL basic_pending: pending=%b sel=%b, want 1 0000", pending, sel_v);
        end
        vecs++;
        @(negedge clk);
        for (int c = 0; c < 26; c++) begin
            d = (c / 3) % 4;
            es = 4'b0001 << d; eg = pat[d]; ef = (c % 12 == 0) && (c > 0);
            if (sel_v !== es || seg !== eg || frame !== ef || pending !== 1'b0) begin
                errs++;
                $display("FAIL basic[%0d]: sel=%b seg=%h frame=%b pend=%b, want %b %h %b 0", c, sel_v, seg, frame, pending, es, eg, ef);
            end
            vecs++;
            @(negedge clk);
        end
    endtask

    task automatic test_blank();
        logic [3:0] es; logic [7:0] eg; logic ef; int ph;
        do_reset();
        start_scan(8'd3, 8'd2, 8'd255);
        for (int c = 0; c < 42; c++) begin
            ph = c % 20;
            es = (ph % 5 < 3) ? (4'b0001 << (ph / 5)) : 4'b0000;
            eg = (ph % 5 < 3) ? pat[ph / 5] : 8'h00;
            ef = (ph == 0) && (c > 0);
            if (sel_v !== es || seg !== eg || frame !== ef) begin
                errs++;
                $display("FAIL blank[%0d]: sel=%b seg=%h frame=%b, want %b %h %b", c, sel_v, seg, frame, es, eg, ef);
            end
            vecs++;
            @(negedge clk);
        end
    endtask

    task automatic test_pwm();
        logic [3:0] es; logic [7:0] eg; logic ef; int d;
        do_reset();
        start_scan(8'd4, 8'd0, 8'd1);
        for (int c = 0; c < 32; c++) begin
            d = (c / 4) % 4;
            es = 4'b0001 << d; eg = (c % 4 == 0) ? pat[d] : 8'h00;
            if (sel_v !== es || seg !== eg) begin
                errs++;
                $display("FAIL pwm_duty1[%0d]: sel=%b seg=%h, want %b %h", c, sel_v, seg, es, eg);
            end
            vecs++;
            @(negedge clk);
        end
        do_reset();
        start_scan(8'd4, 8'd0, 8'd0);
        for (int c = 0; c < 16; c++) begin
            es = 4'b0001 << ((c / 4) % 4);
            if (sel_v !== es || seg !== 8'h00) begin
                errs++;
                $display("FAIL pwm_duty0[%0d]: sel=%b seg=%h, want %b 00", c, sel_v, seg, es);
            end
            vecs++;
            @(negedge clk);
        end
        do_reset();
        start_scan(8'd0, 8'd0, 8'd255);
        for (int c = 0; c < 13; c++) begin
            es = 4'b0001 << (c % 4); eg = pat[c % 4]; ef = (c % 4 == 0) && (c > 0);
            if (sel_v !== es || seg !== eg || frame !== ef) begin
                errs++;
                $display("FAIL dwell0[%0d]: sel=%b seg=%h frame=%b, want %b %h %b", c, sel_v, seg, frame, es, eg, ef);
            end
            vecs++;
            @(negedge clk);
        end
    endtask

    task automatic test_update();
        logic [3:0] es; logic [7:0] eg; logic ef, ep; int d;
        do_reset();
        start_scan(8'd3, 8'd0, 8'd255);
        for (int c = 0; c < 28; c++) begin
            d = (c / 3) % 4;
            es = 4'b0001 << d;
            eg = (d != 0) ? pat[d] : (c < 12) ? 8'h3F : (c < 24) ? 8'h7F : 8'h77;
            ef = (c % 12 == 0) && (c > 0);
            ep = (c >= 5) && (c < 12);
            if (sel_v !== es || seg !== eg || frame !== ef || pending !== ep) begin
                errs++;
                $display("FAIL update[%0d]: sel=%b seg=%h frame=%b pend=%b, want %b %h %b %b", c, sel_v, seg, frame, pending, es, eg, ef, ep);
            end
            vecs++;
            if (c == 4)  begin upd = 1'b1; dig0 = 8'h7F; end
            if (c == 5)  upd = 1'b0;
            if (c == 23) begin upd = 1'b1; dig0 = 8'h77; end
            if (c == 24) upd = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_enable_drop();
        logic [3:0] es; logic [7:0] eg; logic ep; int k;
        do_reset();
        start_scan(8'd3, 8'd0, 8'd255);
        for (int c = 0; c < 23; c++) begin
            if (c < 8) begin
                es = 4'b0001 << (c / 3); eg = pat[c / 3]; ep = (c == 7);
            end else if (c < 11) begin
                es = 4'b0000; eg = 8'h00; ep = 1'b1;
            end else begin
                k = c - 11;
                es = 4'b0001 << (k / 3);
                eg = (k / 3 == 0) ? 8'h11 : pat[k / 3];
                ep = 1'b0;
            end
            if (sel_v !== es || seg !== eg || frame !== 1'b0 || pending !== ep) begin
                errs++;
                $display("FAIL en_drop[%0d]: sel=%b seg=%h frame=%b pend=%b, want %b %h 0 %b", c, sel_v, seg, frame, pending, es, eg, ep);
            end
            vecs++;
            if (c == 6)  begin upd = 1'b1; dig0 = 8'h11; end
            if (c == 7)  begin upd = 1'b0; enable = 1'b0; end
            if (c == 10) enable = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        pat[0] = 8'h3F; pat[1] = 8'h06; pat[2] = 8'h5B; pat[3] = 8'h4F;
        rst = 1'b1; enable = 1'b0; upd = 1'b0;
        dig0 = 8'h00; dig1 = 8'h00; dig2 = 8'h00; dig3 = 8'h00;
        dwell = 8'd1; blank = 8'd0; duty = 8'd255;
        @(negedge clk);
        test_reset();
        test_basic();
        test_blank();
        test_pwm();
        test_update();
        test_enable_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Scan scheduler for the 4-digit multiplexed seven-segment display driven by the cycle counter. It time-shares the single `seg` bus between four digit selects. Each digit gets a programmable dwell, an optional anti-ghosting blank gap, and a PWM brightness duty. Digit patterns are double-buffered so an update never tears mid-frame.

## Interface
Parameters:
- UUID, 0, instance identifier
- NAME, "", instance name

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- enable  in  1  scan enable; low forces idle/dark
- dig0..dig3  in  8 each  segment patterns; dig0→sel1 (least-significant digit) … dig3→sel4
- upd  in  1  capture dig0..dig3 into shadow buffer
- dwell  in  8  ON-phase length in cycles; 0 treated as 1
- blank  in  8  blank-gap length in cycles after each ON phase; 0 = no gap
- duty  in  8  lit cycles at the start of each ON phase; ≥ effective dwell = full brightness
- sel1, sel2, sel3, sel4  out  1 each  digit selects, one-hot or all-zero
- seg  out  8  segment bus
- frame  out  1  one-cycle pulse at frame wrap
- pending  out  1  shadow holds data not yet applied

## Operation
- Registered state: `st` ∈ {IDLE, ON, BLANK}, `idx` (2b), `cnt` (8b), active[4]×8, shadow[4]×8, pending, frame.
- Outputs are Moore-decoded from registered state. No extra output register.
- Reset: st=IDLE, idx=0, cnt=0, active=shadow=0, pending=0, frame=0. All sel=0, seg=0.
- dwell_eff = (dwell==0) ? 1 : dwell. All comparisons are 8-bit unsigned. Config inputs are read live every cycle.
- IDLE:
  - sel=0, seg=0.
  - If enable: go to ON with idx=0, cnt=0, and perform a boundary apply.
- ON:
  - sel[idx]=1.
  - seg = active[idx] when cnt < duty, else 0.
  - If cnt ≥ dwell_eff−1: go to BLANK with cnt=0 when blank≠0; otherwise advance. Else cnt++.
- BLANK:
  - sel=0, seg=0.
  - If cnt ≥ blank−1: advance. Else cnt++.
- Advance:
  - cnt=0, st=ON.
  - If idx==3: idx=0, frame=1 next cycle, boundary apply. Else idx++.
- Boundary apply:
  - If upd is high this cycle: active←dig0..3 directly, pending←0.
  - Else if pending: active←shadow, pending←0.
- upd outside a boundary cycle: shadow←dig0..3, pending←1. A later upd overwrites the shadow (last write wins).
- enable low in ON or BLANK: next state IDLE, idx=0, cnt=0. No frame pulse. Shadow and pending are retained.
- rst overrides everything, including enable and upd in the same cycle.

## Timing
- Frame period = 4·(dwell_eff+blank) cycles; for example, dwell=3, blank=2 gives 20.
- First lit cycle is the cycle after enable is sampled high in IDLE. sel1 asserts in that same cycle.
- frame is high for exactly the first cycle of the new frame's sel1 ON phase.
- pending rises the cycle after upd and falls the cycle after the frame boundary.
- Shortening dwell or blank mid-phase ends the phase on the next cycle at the latest (≥ compare). Lengthening extends the current phase.
- duty=0 keeps seg dark while sel still scans.

## Test plan
- Reset: hold rst 2 cycles with enable=1 and upd=1 → sel1..4=0, seg=0, frame=0, pending=0. Release rst with enable=0 → outputs stay 0.
- Basic scan: dig=3F/06/5B/4F, dwell=3, blank=0, duty=255; pulse upd, then enable.
  - Expected: sel1+seg=3F for 3 cycles, then sel2/06, sel3/5B, sel4/4F, 3 cycles each.
  - frame pulses every 12 cycles. Selects are always one-hot.
- Blanking: dwell=3, blank=2.
  - Expected per digit: 3 lit cycles, then 2 cycles with all sel=0 and seg=0. frame period 20.
- PWM: dwell=4, duty=1, blank=0.
  - Expected: each sel held 4 cycles, seg=pattern only in the first of them, 0 otherwise.
  - duty=0 → seg always 0. dwell=0 → each digit held 1 cycle, period 4.
- Update sync: mid-frame, pulse upd with dig0=7F.
  - Expected: pending=1 and the display stays unchanged until wrap. From the frame-pulse cycle, sel1 shows 7F and pending=0.
  - upd asserted on the wrap cycle itself → new data shown immediately, pending stays 0.
- Enable drop: deassert enable during the sel3 ON phase.
  - Expected: next cycle all outputs 0 and no frame pulse. Re-enable restarts at sel1 with cnt=0.
